// File: rtl/fm_demod_controller_if.sv
// Sample input, recalibration request and sliced-bit/status outputs of the FM demod controller.
interface fm_demod_controller_if #(
    parameter int SAMPLE_BITS = 16
);
    logic [SAMPLE_BITS-1:0] sample;
    logic                   sample_valid;
    logic                   recal_req;
    logic [SAMPLE_BITS-1:0] compare_point;
    logic                   locked;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   cal_fail;
    logic                   lost_signal;

    modport master (
        output sample, sample_valid, recal_req,
        input  compare_point, locked, bit_out, bit_valid, cal_fail, lost_signal
    );

    modport slave (
        input  sample, sample_valid, recal_req,
        output compare_point, locked, bit_out, bit_valid, cal_fail, lost_signal
    );
endinterface

// File: rtl/fm_demod_controller.sv
// Calibrates the period-count threshold from live samples, then slices each sample into a data bit.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_CAL    | collecting a min/max window to derive compare_point
// ST_LOCKED | threshold valid; each sample_valid yields a bit one cycle later
module fm_demod_controller #(
    parameter int SAMPLE_BITS     = 16,
    parameter int CAL_SAMPLES     = 64,
    parameter int MIN_SPAN        = 4,
    parameter int TIMEOUT_CYCLES  = 4000,
    parameter int DEFAULT_COMPARE = 200
) (
    input  logic                 clk_200M,
    input  logic                 reset_200M,
    fm_demod_controller_if.slave bus
);
    localparam int CNT_W = $clog2(CAL_SAMPLES) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_CAL    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SAMPLE_BITS-1:0] cp_q, cp_d;
    logic [SAMPLE_BITS-1:0] min_q, min_d;
    logic [SAMPLE_BITS-1:0] max_q, max_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   bit_out_q, bit_out_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   cal_fail_q, cal_fail_d;
    logic                   lost_q, lost_d;

    logic [SAMPLE_BITS-1:0] next_min, next_max, span, mid;
    logic [SAMPLE_BITS:0]   sum;
    logic                   timeout, window_end, restart;

    // Window statistics including the sample arriving this cycle.
    always_comb begin
        next_min = min_q;
        next_max = max_q;
        if (bus.sample_valid) begin
            if (bus.sample < min_q) next_min = bus.sample;
            if (bus.sample > max_q) next_max = bus.sample;
        end
        span = next_max - next_min;
        // Extra sum bit keeps the midpoint exact when both extremes are near all-ones.
        sum  = {1'b0, next_min} + {1'b0, next_max};
        mid  = SAMPLE_BITS'(sum >> 1);
    end

    assign timeout    = !bus.sample_valid && (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1));
    assign window_end = bus.sample_valid && (cnt_q == CNT_W'(CAL_SAMPLES - 1));

    always_comb begin
        state_d     = state_q;
        cp_d        = cp_q;
        min_d       = min_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        cal_fail_d  = 1'b0;
        lost_d      = lost_q;
        timer_d     = timer_q;
        restart     = 1'b0;

        if (bus.sample_valid || timeout) begin
            timer_d = '0;
        end else if (timer_q != {TMR_W{1'b1}}) begin
            timer_d = timer_q + TMR_W'(1);
        end

        case (state_q)
            ST_CAL: begin
                if (bus.recal_req) begin
                    restart = 1'b1;
                end else if (timeout) begin
                    lost_d  = 1'b1;
                    restart = 1'b1;
                end else if (bus.sample_valid) begin
                    min_d = next_min;
                    max_d = next_max;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (window_end) begin
                        restart = 1'b1;
                        if (span >= SAMPLE_BITS'(MIN_SPAN)) begin
                            cp_d    = mid;
                            lost_d  = 1'b0;
                            state_d = ST_LOCKED;
                        end else begin
                            cal_fail_d = 1'b1;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.recal_req) begin
                    state_d = ST_CAL;
                    restart = 1'b1;
                end else if (timeout) begin
                    lost_d  = 1'b1;
                    state_d = ST_CAL;
                    restart = 1'b1;
                end else if (bus.sample_valid) begin
                    bit_valid_d = 1'b1;
                    bit_out_d   = (bus.sample < cp_q);
                end
            end
            default: begin
                state_d = ST_CAL;
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            min_d = '1;
            max_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_200M) begin
        if (reset_200M) begin
            state_q     <= ST_CAL;
            cp_q        <= SAMPLE_BITS'(DEFAULT_COMPARE);
            min_q       <= '1;
            max_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            cal_fail_q  <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cp_q        <= cp_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            cal_fail_q  <= cal_fail_d;
            lost_q      <= lost_d;
        end
    end

    assign bus.compare_point = cp_q;
    assign bus.locked        = (state_q == ST_LOCKED);
    assign bus.bit_out       = bit_out_q;
    assign bus.bit_valid     = bit_valid_q;
    assign bus.cal_fail      = cal_fail_q;
    assign bus.lost_signal   = lost_q;
endmodule
